// File: rtl/uart_word_loader.sv
// uart_word_loader
//   Serial front end of the UART-to-BRAM program loader. Receives 8N1 bytes on
//   rx, packs byte pairs big-endian into 16-bit words and writes each word to
//   the BRAM I/O port at auto-incrementing addresses while enable is high.
//
// Ports
//   clk_100     in   system clock
//   rst         in   synchronous active-high reset
//   rx          in   asynchronous UART serial input, idle high
//   enable      in   load mode; the packer runs only while high
//   addr_io     out  [15:0] BRAM write address
//   data_in_io  out  [15:0] BRAM write data
//   we_io       out  BRAM write enable, one-cycle pulse per word
//   led_rx      out  high while a frame is being received
//   done        out  sticky, LOAD_WORDS words written
//   frame_err   out  sticky, a stop bit sampled low
module uart_word_loader #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned LOAD_WORDS   = 256
) (
    input  logic        clk_100,
    input  logic        rst,
    input  logic        rx,
    input  logic        enable,
    output logic [15:0] addr_io,
    output logic [15:0] data_in_io,
    output logic        we_io,
    output logic        led_rx,
    output logic        done,
    output logic        frame_err
);

    localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_CNT  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [15:0]   LAST_ADDR = 16'(LOAD_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t          state;
    logic            rx_meta;
    logic            rxs;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            byte_valid;
    logic            pending;
    logic [7:0]      high_byte;

    // Receiver: 2-FF synchronizer, bit timing and framing.
    always_ff @(posedge clk_100) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            state      <= StIdle;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            led_rx     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rxs        <= rx_meta;
            byte_valid <= 1'b0;
            led_rx     <= (state != StIdle);
            case (state)
                StIdle: begin
                    if (!rxs) begin
                        state   <= StStart;
                        bit_cnt <= '0;
                    end
                end
                StStart: begin
                    // Mid start bit: a high line here was only a glitch.
                    if (bit_cnt == HALF_CNT) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? StIdle : StData;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (bit_cnt == LAST_CNT) begin
                        bit_cnt <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= StStop;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                StStop: begin
                    // Sampled mid stop bit, so the next start edge is not missed.
                    if (bit_cnt == LAST_CNT) begin
                        bit_cnt <= '0;
                        state   <= StIdle;
                        if (rxs) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Packer: pairs bytes into words and drives the BRAM write port.
    always_ff @(posedge clk_100) begin
        if (rst) begin
            addr_io    <= '0;
            data_in_io <= '0;
            we_io      <= 1'b0;
            done       <= 1'b0;
            pending    <= 1'b0;
            high_byte  <= '0;
        end else begin
            we_io <= 1'b0;
            if (!enable) begin
                // Dropping load mode takes priority over a coincident byte.
                pending <= 1'b0;
                addr_io <= '0;
                done    <= 1'b0;
            end else begin
                // Address advances the cycle after the write unless the
                // final word was just written.
                if (we_io && !done) begin
                    addr_io <= addr_io + 16'd1;
                end
                if (byte_valid && !done) begin
                    if (!pending) begin
                        high_byte <= shreg;
                        pending   <= 1'b1;
                    end else begin
                        data_in_io <= {high_byte, shreg};
                        we_io      <= 1'b1;
                        pending    <= 1'b0;
                        if (addr_io == LAST_ADDR) begin
                            done <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_word_loader.sv
// Testbench for uart_word_loader: directed and random UART frames, with a
// word-level reference model feeding a queue that a write monitor drains.
module tb_uart_word_loader;

    localparam int unsigned CPB = 16;
    localparam int unsigned LW  = 3;

    logic        clk_100 = 1'b0;
    logic        rst     = 1'b1;
    logic        rx      = 1'b1;
    logic        enable  = 1'b0;
    logic [15:0] addr_io;
    logic [15:0] data_in_io;
    logic        we_io;
    logic        led_rx;
    logic        done;
    logic        frame_err;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] exp_q[$];
    bit          m_en;
    bit          m_pend;
    logic [7:0]  m_hi;
    int          m_addr;
    bit          m_done;
    bit          m_ferr;

    uart_word_loader #(
        .CLKS_PER_BIT(CPB),
        .LOAD_WORDS  (LW)
    ) dut (
        .clk_100   (clk_100),
        .rst       (rst),
        .rx        (rx),
        .enable    (enable),
        .addr_io   (addr_io),
        .data_in_io(data_in_io),
        .we_io     (we_io),
        .led_rx    (led_rx),
        .done      (done),
        .frame_err (frame_err)
    );

    always #5 clk_100 = ~clk_100;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the next expected word, one cycle wide.
    logic prev_we = 1'b0;
    always @(negedge clk_100) begin
        if (we_io) begin
            if (prev_we) begin
                chk("we_pulse_width", 2, 1);
            end
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {16'(addr_io), 16'(data_in_io)}, 0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("write_addr", int'(addr_io), int'(e[31:16]));
                chk("write_data", int'(data_in_io), int'(e[15:0]));
            end
        end
        prev_we <= we_io;
    end

    task automatic model_reset();
        m_pend = 0;
        m_addr = 0;
        m_done = 0;
        m_ferr = 0;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            m_ferr = 1;
        end else if (m_en && !m_done) begin
            if (!m_pend) begin
                m_hi   = b;
                m_pend = 1;
            end else begin
                exp_q.push_back({16'(m_addr), m_hi, b});
                m_pend = 0;
                if (m_addr == LW - 1) m_done = 1;
                else m_addr++;
            end
        end
    endtask

    task automatic set_enable(input bit v);
        @(negedge clk_100);
        enable = v;
        m_en   = v;
        if (!v) begin
            m_pend = 0;
            m_addr = 0;
            m_done = 0;
        end
        repeat (2) @(negedge clk_100);
    endtask

    // Sends one frame; rst_bit >= 0 pulses rst in the middle of that frame bit
    // and the byte is then expected to be lost.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int rst_bit);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        if (rst_bit < 0) model_byte(b, stop_ok);
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            for (int c = 0; c < int'(CPB); c++) begin
                @(negedge clk_100);
                if (i == rst_bit && c == int'(CPB / 2)) begin
                    chk("led_rx_mid_frame", int'(led_rx), 1);
                    rst = 1'b1;
                end
                if (i == rst_bit && c == int'(CPB / 2) + 1) begin
                    rst = 1'b0;
                    model_reset();
                    chk("rst_addr", int'(addr_io), 0);
                    chk("rst_data", int'(data_in_io), 0);
                    chk("rst_we", int'(we_io), 0);
                    chk("rst_led", int'(led_rx), 0);
                    chk("rst_done", int'(done), 0);
                    chk("rst_ferr", int'(frame_err), 0);
                end
            end
        end
        rx = 1'b1;
        repeat (4) @(negedge clk_100);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_done"}, int'(done), int'(m_done));
        chk({tag, "_ferr"}, int'(frame_err), int'(m_ferr));
        chk({tag, "_addr"}, int'(addr_io), m_addr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] rb;
        m_en = 0;
        model_reset();
        repeat (3) @(negedge clk_100);
        chk("reset_addr", int'(addr_io), 0);
        chk("reset_data", int'(data_in_io), 0);
        chk("reset_we", int'(we_io), 0);
        chk("reset_led", int'(led_rx), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ferr", int'(frame_err), 0);
        rst = 1'b0;

        // Two words at consecutive addresses.
        set_enable(1);
        send_byte(8'h12, 1, -1);
        send_byte(8'h34, 1, -1);
        check_state("w0");
        send_byte(8'hAB, 1, -1);
        send_byte(8'hCD, 1, -1);
        check_state("w1");

        // Bad stop bit: error, no effect on packing.
        send_byte(8'h55, 0, -1);
        check_state("ferr");
        send_byte(8'h00, 1, -1);
        send_byte(8'h01, 1, -1);
        check_state("last_word");
        chk("done_set", int'(done), 1);
        chk("addr_hold", int'(addr_io), LW - 1);
        send_byte(8'h77, 1, -1);
        send_byte(8'h88, 1, -1);
        check_state("after_done");

        // Reset mid-frame drops a pending byte and everything sticky.
        set_enable(0);
        set_enable(1);
        send_byte(8'h77, 1, -1);
        send_byte(8'hFC, 1, 4);
        send_byte(8'hDE, 1, -1);
        send_byte(8'hAD, 1, -1);
        check_state("post_rst");

        // Short low glitch: false start.
        @(negedge clk_100);
        rx = 1'b0;
        repeat (5) @(negedge clk_100);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk_100);
        chk("glitch_led", int'(led_rx), 0);
        chk("glitch_ferr", int'(frame_err), 0);

        // Disabled bytes are ignored; enable drop loses the pending byte.
        set_enable(0);
        send_byte(8'h11, 1, -1);
        send_byte(8'h22, 1, -1);
        check_state("disabled");
        set_enable(1);
        send_byte(8'h33, 1, -1);
        set_enable(0);
        set_enable(1);
        send_byte(8'h44, 1, -1);
        send_byte(8'h55, 1, -1);
        check_state("reenable");

        // Random traffic with occasional bad stops and enable drops.
        for (int i = 0; i < 16; i++) begin
            rb = 8'($urandom_range(255, 0));
            if ($urandom_range(7, 0) == 0) begin
                set_enable(0);
                set_enable(1);
            end
            send_byte(rb, ($urandom_range(7, 0) != 0), -1);
            check_state("rand");
        end

        repeat (10) @(negedge clk_100);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
